// File: rtl/vswap_engine.sv
// vswap_engine: burst swap/copy engine between two memories, one word per READ/WRITE cycle pair.
module vswap_engine #(
    parameter int AW = 32,
    parameter int DW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] addra,
    input  logic [AW-1:0] addrb,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_a_raddr,
    output logic          mem_a_ren,
    input  logic [DW-1:0] mem_a_rdata,
    output logic [AW-1:0] mem_a_waddr,
    output logic [DW-1:0] mem_a_wdata,
    output logic          mem_a_wen,
    output logic [AW-1:0] mem_b_raddr,
    output logic          mem_b_ren,
    input  logic [DW-1:0] mem_b_rdata,
    output logic [AW-1:0] mem_b_waddr,
    output logic [DW-1:0] mem_b_wdata,
    output logic          mem_b_wen
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;
    logic [1:0]    state, mode_q;
    logic [AW-1:0] base_a, base_b;
    logic [LW-1:0] len_q, i, i_nx;
    logic [DW-1:0] buf_a, buf_b;
    logic          src_a, src_b;
    // A is read for swap and A->B copy; B is read for swap and B->A copy
    assign src_a = mode_q != 2'd2;
    assign src_b = mode_q != 2'd1;
    assign i_nx = i + LW'(1);
    // Enables decode straight from state so an async reset kills them at once
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign mem_a_ren = state == READ && src_a;
    assign mem_b_ren = state == READ && src_b;
    assign mem_a_wen = state == WRITE && src_b;
    assign mem_b_wen = state == WRITE && src_a;
    assign mem_a_wdata = buf_b;
    assign mem_b_wdata = buf_a;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mode_q <= 2'd0;
            base_a <= '0;
            base_b <= '0;
            len_q <= '0;
            i <= '0;
            buf_a <= '0;
            buf_b <= '0;
            err <= 1'b0;
            mem_a_raddr <= '0;
            mem_b_raddr <= '0;
            mem_a_waddr <= '0;
            mem_b_waddr <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (mode == 2'd3) begin
                        err <= 1'b1;
                    end else begin
                        mode_q <= mode;
                        base_a <= addra;
                        base_b <= addrb;
                        len_q <= len;
                        i <= '0;
                        state <= len != '0 ? READ : DONE;
                        if (len != '0 && mode != 2'd2) mem_a_raddr <= addra;
                        if (len != '0 && mode != 2'd1) mem_b_raddr <= addrb;
                    end
                end
                READ: begin
                    if (src_a) buf_a <= mem_a_rdata;
                    if (src_b) buf_b <= mem_b_rdata;
                    if (src_b) mem_a_waddr <= base_a + AW'(i);
                    if (src_a) mem_b_waddr <= base_b + AW'(i);
                    state <= WRITE;
                end
                WRITE: begin
                    if (i == len_q - LW'(1)) begin
                        state <= DONE;
                    end else begin
                        i <= i_nx;
                        if (src_a) mem_a_raddr <= base_a + AW'(i_nx);
                        if (src_b) mem_b_raddr <= base_b + AW'(i_nx);
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vswap_engine.sv
// tb_vswap_engine: directed and random bursts checked against a word-level swap/copy model.
module tb_vswap_engine;
    localparam int AW = 32, DW = 8, LW = 4;
    logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, err;
    logic [AW-1:0] mem_a_raddr, mem_a_waddr, mem_b_raddr, mem_b_waddr;
    logic          mem_a_ren, mem_a_wen, mem_b_ren, mem_b_wen;
    logic [DW-1:0] mem_a_rdata, mem_a_wdata, mem_b_rdata, mem_b_wdata;
    logic [DW-1:0] ma [1024], mb [1024], ra [1024], rb [1024];
    int vec = 0, miss = 0;

    vswap_engine #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .addra(addra), .addrb(addrb), .len(len),
        .busy(busy), .done(done), .err(err),
        .mem_a_raddr(mem_a_raddr), .mem_a_ren(mem_a_ren), .mem_a_rdata(mem_a_rdata),
        .mem_a_waddr(mem_a_waddr), .mem_a_wdata(mem_a_wdata), .mem_a_wen(mem_a_wen),
        .mem_b_raddr(mem_b_raddr), .mem_b_ren(mem_b_ren), .mem_b_rdata(mem_b_rdata),
        .mem_b_waddr(mem_b_waddr), .mem_b_wdata(mem_b_wdata), .mem_b_wen(mem_b_wen)
    );

    // 1024-word memories; the low address bits select the word, so 0xFFFFFFFF and 0 stay distinct
    assign mem_a_rdata = ma[mem_a_raddr[9:0]];
    assign mem_b_rdata = mb[mem_b_raddr[9:0]];
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_mem();
        int bad = 0;
        for (int k = 0; k < 1024; k++) if (ma[k] !== ra[k] || mb[k] !== rb[k]) bad++;
        chk("mem_contents", 32'(bad), 32'd0);
    endtask

    task automatic preload();
        for (int k = 0; k < 1024; k++) begin
            ma[k] = DW'($urandom);
            mb[k] = DW'($urandom);
        end
    endtask

    // Runs one burst; abort_at>0 asserts rst in that cycle after start instead of finishing
    task automatic run_op(input logic [1:0] m, input logic [31:0] aa, input logic [31:0] ab,
                          input int n, input int abort_at);
        int last, words;
        logic [31:0] xa, xb;
        logic [DW-1:0] t;
        logic rd, wr, sa, sb;
        last = (n == 0) ? 1 : 2 * n + 1;
        words = (abort_at > 0) ? (abort_at - 1) / 2 : n;
        sa = m != 2'd2;
        sb = m != 2'd1;
        ra = ma;
        rb = mb;
        for (int k = 0; k < words; k++) begin
            xa = aa + 32'(k);
            xb = ab + 32'(k);
            t = ra[xa[9:0]];
            if (m != 2'd2) rb[xb[9:0]] = t;
            if (m != 2'd1) ra[xa[9:0]] = (m == 2'd0) ? mb[xb[9:0]] : rb[xb[9:0]];
        end
        @(negedge clk);
        start = 1'b1; mode = m; addra = aa; addrb = ab; len = LW'(n);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_wen", 32'({mem_a_wen, mem_b_wen, mem_a_ren, mem_b_ren}), 32'd0);
                break;
            end
            rd = (c % 2 == 1) && c < 2 * n;
            wr = (c % 2 == 0) && c <= 2 * n;
            chk("busy", 32'(busy), 32'(c <= last));
            chk("done", 32'(done), 32'(c == last));
            chk("ren_a", 32'(mem_a_ren), 32'(rd && sa));
            chk("ren_b", 32'(mem_b_ren), 32'(rd && sb));
            chk("wen_a", 32'(mem_a_wen), 32'(wr && sb));
            chk("wen_b", 32'(mem_b_wen), 32'(wr && sa));
            if (rd && sa) chk("raddr_a", mem_a_raddr, aa + 32'((c - 1) / 2));
            if (rd && sb) chk("raddr_b", mem_b_raddr, ab + 32'((c - 1) / 2));
            if (wr && sb) chk("waddr_a", mem_a_waddr, aa + 32'((c - 2) / 2));
            if (wr && sa) chk("waddr_b", mem_b_waddr, ab + 32'((c - 2) / 2));
            if (mem_a_wen) ma[mem_a_waddr[9:0]] = mem_a_wdata;
            if (mem_b_wen) mb[mem_b_waddr[9:0]] = mem_b_wdata;
        end
        chk_mem();
    endtask

    initial begin
        preload();
        #2 rst = 1'b1;
        #1;
        chk("rst_flags", 32'({busy, done, err}), 32'd0);
        chk("rst_en", 32'({mem_a_ren, mem_b_ren, mem_a_wen, mem_b_wen}), 32'd0);
        chk("rst_addr", mem_a_raddr | mem_b_raddr | mem_a_waddr | mem_b_waddr, 32'd0);
        chk("rst_wdata", 32'({mem_a_wdata, mem_b_wdata}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // single-word swap with known values
        ma[10'h10] = 8'hAA;
        mb[10'h20] = 8'h55;
        run_op(2'd0, 32'h10, 32'h20, 1, 0);
        chk("swap1_a", 32'(ma[10'h10]), 32'h55);
        chk("swap1_b", 32'(mb[10'h20]), 32'hAA);
        for (int k = 0; k < 4; k++) begin
            ma[10'h100 + 10'(k)] = 8'h10 + 8'(k);
            mb[10'h200 + 10'(k)] = 8'hE0 + 8'(k);
        end
        run_op(2'd0, 32'h100, 32'h200, 4, 0);
        run_op(2'd1, 32'h30, 32'h50, 3, 0);
        run_op(2'd2, 32'h60, 32'h90, 3, 0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'h10, 2, 0);
        run_op(2'd1, 32'h5, 32'h7, 0, 0);
        // reserved mode
        @(negedge clk);
        start = 1'b1; mode = 2'd3;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_en", 32'({mem_a_ren, mem_b_ren, mem_a_wen, mem_b_wen}), 32'd0);
        @(negedge clk);
        chk("err_clear", 32'(err), 32'd0);
        // reset during WRITE of word 1 of a four-word swap
        run_op(2'd0, 32'h40, 32'h80, 4, 4);
        chk("abort_raddr", mem_a_raddr | mem_b_raddr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_nodone", 32'({done, busy}), 32'd0);
        run_op(2'd0, 32'h40, 32'h80, 4, 0);
        for (int r = 0; r < 20; r++)
            run_op(2'($urandom_range(2)), 32'($urandom_range(32'h2F0)), 32'($urandom_range(32'h2F0)),
                   int'($urandom_range(15)), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
